// File: rtl/adc_capture_engine_if.sv
// AXI-Stream style handshake bundle shared by the ADC input
// and the capture-buffer output of adc_capture_engine.
interface adc_capture_engine_if #(
   parameter int W = 128
) ();
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/adc_capture_engine.sv
// ADC front-end: pipelined per-word peak/lane detector plus
// triggered raw-word capture FIFO drained over AXI-Stream.
module adc_capture_engine #(
   parameter int SAMPLE_W   = 16,
   parameter int N_LANES    = 8,
   parameter int DEPTH_LOG2 = 10,
   localparam int LW = $clog2(N_LANES),
   localparam int DW = SAMPLE_W * N_LANES,
   localparam int CW = DEPTH_LOG2 + 1
) (
   input  logic                clk,
   input  logic                rst,
   adc_capture_engine_if.slave  s_axis,
   adc_capture_engine_if.master m_axis,
   input  logic                cfg_mode,
   input  logic [LW-1:0]       cfg_lane,
   input  logic [CW-1:0]       cfg_len,
   input  logic                det_run,
   output logic [SAMPLE_W-1:0] det_out,
   output logic [LW-1:0]       det_pos,
   output logic                det_valid,
   input  logic                trig,
   output logic                busy,
   output logic                overflow
);
   localparam int NS    = LW;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAP,
      S_WAIT
   } state_t;

   // ---------------- detector ----------------
   logic [SAMPLE_W-1:0] w_smp [N_LANES];
   logic [SAMPLE_W-1:0] w_mag [N_LANES];

   logic [SAMPLE_W-1:0] r_mag [0:NS][0:N_LANES-1];
   logic [SAMPLE_W-1:0] r_smp [0:NS][0:N_LANES-1];
   logic [LW-1:0]       r_idx [0:NS][0:N_LANES-1];
   logic [NS:0]         r_vld;

   // Lane split and magnitude; fixed-lane mode rigs the key so the tree picks cfg_lane
   always_comb begin
      for (int i = 0; i < N_LANES; i++) begin
         w_smp[i] = s_axis.tdata[i*SAMPLE_W +: SAMPLE_W];
         w_mag[i] = '0;
         if (cfg_mode) begin
            w_mag[i] = (LW'(i) == cfg_lane) ? '1 : '0;
         end else if (w_smp[i][SAMPLE_W-1]) begin
            w_mag[i] = (w_smp[i] == S_MIN) ? S_MAX : -w_smp[i];
         end else begin
            w_mag[i] = w_smp[i];
         end
      end
   end

   // Magnitude stage then binary compare tree; ties keep the lower lane
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld <= '0;
         for (int k = 0; k <= NS; k++) begin
            for (int j = 0; j < N_LANES; j++) begin
               r_mag[k][j] <= '0;
               r_smp[k][j] <= '0;
               r_idx[k][j] <= '0;
            end
         end
      end else begin
         r_vld[0] <= s_axis.tvalid & det_run;
         for (int j = 0; j < N_LANES; j++) begin
            r_mag[0][j] <= w_mag[j];
            r_smp[0][j] <= w_smp[j];
            r_idx[0][j] <= LW'(j);
         end
         for (int k = 1; k <= NS; k++) begin
            r_vld[k] <= r_vld[k-1];
            for (int j = 0; j < N_LANES / 2; j++) begin
               if (r_mag[k-1][2*j+1] > r_mag[k-1][2*j]) begin
                  r_mag[k][j] <= r_mag[k-1][2*j+1];
                  r_smp[k][j] <= r_smp[k-1][2*j+1];
                  r_idx[k][j] <= r_idx[k-1][2*j+1];
               end else begin
                  r_mag[k][j] <= r_mag[k-1][2*j];
                  r_smp[k][j] <= r_smp[k-1][2*j];
                  r_idx[k][j] <= r_idx[k-1][2*j];
               end
            end
            for (int j = N_LANES / 2; j < N_LANES; j++) begin
               r_mag[k][j] <= '0;
               r_smp[k][j] <= '0;
               r_idx[k][j] <= '0;
            end
         end
      end
   end

   assign det_out   = r_smp[NS][0];
   assign det_pos   = r_idx[NS][0];
   assign det_valid = r_vld[NS];

   // ---------------- capture FIFO ----------------
   logic [DW:0]         r_mem [0:DEPTH-1];
   logic [CW-1:0]       r_wp;
   logic [CW-1:0]       r_rp;
   logic [CW-1:0]       r_cnt;
   state_t              r_state;
   logic                r_busy;
   logic                r_ovf;
   logic                w_empty;
   logic                w_full;
   logic                w_rd;
   logic                w_wreq;
   logic                w_we;
   logic                w_last;
   logic [DW:0]         w_head;

   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[CW-1] != r_rp[CW-1]) &&
                    (r_wp[CW-2:0] == r_rp[CW-2:0]);
   assign w_rd    = !w_empty & m_axis.tready;
   assign w_wreq  = (r_state == S_CAP) & s_axis.tvalid;
   assign w_we    = w_wreq & (!w_full | w_rd);
   assign w_last  = (r_cnt == CW'(1));
   assign w_head  = r_mem[r_rp[CW-2:0]];

   assign s_axis.tready = 1'b1;
   assign m_axis.tvalid = !w_empty;
   assign m_axis.tdata  = w_empty ? '0 : w_head[DW-1:0];
   assign m_axis.tlast  = w_empty ? 1'b0 : w_head[DW];
   assign busy          = r_busy;
   assign overflow      = r_ovf;

   // Storage array, written with the raw word and its last tag
   always_ff @(posedge clk) begin
      if (w_we) r_mem[r_wp[CW-2:0]] <= {w_last, s_axis.tdata};
   end

   // Pointers and sticky overflow; a read frees the slot a same-cycle write uses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_we) r_wp <= r_wp + CW'(1);
         if (w_rd) r_rp <= r_rp + CW'(1);
         if (w_wreq & !w_we) r_ovf <= 1'b1;
      end
   end

   // Capture FSM: one capture per trigger level, length latched at trigger
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (trig) begin
                  r_cnt <= cfg_len;
                  if (cfg_len == '0) begin
                     r_state <= S_WAIT;
                  end else begin
                     r_state <= S_CAP;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_CAP: begin
               if (s_axis.tvalid) begin
                  r_cnt <= r_cnt - CW'(1);
                  if (w_last) begin
                     r_state <= S_WAIT;
                     r_busy  <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (!trig) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule
